// File: rtl/mem_noc_arbiter_2to1_pkg.sv
// Shared request/response types and master ids for the 2:1 memory NoC arbiter.
package mem_noc_arbiter_2to1_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } noc_mid_t;

    function automatic noc_mid_t other_mid(input noc_mid_t m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/noc_id_fifo.sv
// In-order FIFO recording the owner of each in-flight NoC request.
module noc_id_fifo #(
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      cnt
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign cnt   = cnt_q;

endmodule

// File: rtl/mem_noc_arbiter_2to1.sv
// Round-robin 2:1 merge of fetch and load/store masters onto one NoC port,
// steering each response back to the master that issued the request.
module mem_noc_arbiter_2to1
    import mem_noc_arbiter_2to1_pkg::*;
#(
    parameter int unsigned OSTD_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      m0_req_valid,
    output logic      m0_req_ready,
    input  mem_req_t  m0_req,
    output logic      m0_resp_valid,
    input  logic      m0_resp_ready,
    output mem_resp_t m0_resp,
    input  logic      m1_req_valid,
    output logic      m1_req_ready,
    input  mem_req_t  m1_req,
    output logic      m1_resp_valid,
    input  logic      m1_resp_ready,
    output mem_resp_t m1_resp,
    output logic      mn_req_valid,
    input  logic      mn_req_ready,
    output mem_req_t  mn_req,
    input  logic      mn_resp_valid,
    output logic      mn_resp_ready,
    input  mem_resp_t mn_resp
);

    localparam int unsigned CW = $clog2(OSTD_DEPTH) + 1;

    noc_mid_t      grant;
    noc_mid_t      head;
    logic          head_id;
    logic          empty;
    logic          full;
    logic [CW-1:0] fifo_cnt;
    logic          resp_pop;
    logic          can_issue;
    logic          issue;

    noc_mid_t rr_ptr_q, rr_ptr_d;
    noc_mid_t lock_id_q, lock_id_d;
    logic     lock_q, lock_d;

    assign head = noc_mid_t'(head_id);

    always_comb begin
        if (lock_q) begin
            grant = lock_id_q;
        end else if (m0_req_valid && !m1_req_valid) begin
            grant = M0;
        end else if (m1_req_valid && !m0_req_valid) begin
            grant = M1;
        end else begin
            grant = rr_ptr_q;
        end
    end

    assign resp_pop      = mn_resp_valid && mn_resp_ready;
    assign mn_resp_ready = !empty &&
                           ((head == M1) ? m1_resp_ready : m0_resp_ready);
    assign m0_resp_valid = mn_resp_valid && !empty && (head == M0);
    assign m1_resp_valid = mn_resp_valid && !empty && (head == M1);
    assign m0_resp       = mn_resp;
    assign m1_resp       = mn_resp;

    // A slot freed by this cycle's response can be reused immediately.
    assign can_issue    = (fifo_cnt < CW'(OSTD_DEPTH)) || resp_pop;
    assign mn_req_valid = can_issue &&
                          ((grant == M1) ? m1_req_valid : m0_req_valid);
    assign mn_req       = (grant == M1) ? m1_req : m0_req;
    assign m0_req_ready = can_issue && mn_req_ready && (grant == M0);
    assign m1_req_ready = can_issue && mn_req_ready && (grant == M1);
    assign issue        = mn_req_valid && mn_req_ready;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (issue) begin
            rr_ptr_d = other_mid(grant);
            lock_d   = 1'b0;
        end else if (mn_req_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q  <= M0;
            lock_q    <= 1'b0;
            lock_id_q <= M0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    noc_id_fifo #(
        .WIDTH (1),
        .DEPTH (OSTD_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (issue),
        .push_data (grant),
        .pop       (resp_pop),
        .head      (head_id),
        .empty     (empty),
        .full      (full),
        .cnt       (fifo_cnt)
    );

    resp_without_req: assert property (
        @(posedge clk) disable iff (!rstn) !(mn_resp_valid && empty)
    );

    issue_when_full: assert property (
        @(posedge clk) disable iff (!rstn) !(issue && full && !resp_pop)
    );

endmodule
